// File: rtl/replica_pkg.sv
// Shared types for the host-side AXI4-Lite master: response codes, FSM states
// and the latched command record.
package replica_pkg;

  localparam int unsigned HOST_ADDR_W = 32;
  localparam int unsigned HOST_DATA_W = 64;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } host_state_t;

  typedef struct packed {
    logic                     write;
    logic [HOST_ADDR_W-1:0]   addr;
    logic [HOST_DATA_W-1:0]   wdata;
    logic [HOST_DATA_W/8-1:0] wstrb;
  } host_cmd_t;

endpackage

// File: rtl/axi_host_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AW+W/B or AR/R
// transaction out, one response back with a saturating latency count.
module axi_host_master
  import replica_pkg::*;
#(
  parameter int unsigned ADDR_W = HOST_ADDR_W,
  parameter int unsigned DATA_W = HOST_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [CNT_W-1:0]    rsp_cycles,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  host_state_t       r_state;
  host_cmd_t         r_cmd;
  logic              r_cmd_ready;
  logic              r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic              r_aw_done, r_w_done;
  logic              r_rsp_valid, r_rsp_write;
  logic [DATA_W-1:0] r_rdata;
  axi_resp_t         r_resp;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_aw_done, w_w_done;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_aw_done = r_aw_done | (r_awvalid & M_AXI_AWREADY);
  assign w_w_done  = r_w_done  | (r_wvalid  & M_AXI_WREADY);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= OKAY;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cmd       <= '{write: cmd_write, addr: cmd_addr,
                             wdata: cmd_wdata, wstrb: cmd_wstrb};
            r_cmd_ready <= 1'b0;
            // The accept cycle itself is the first counted cycle.
            r_cnt       <= CNT_W'(1);
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          r_cnt     <= w_cnt_inc;
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          r_cnt <= w_cnt_inc;
          if (M_AXI_BVALID) begin
            r_resp      <= axi_resp_t'(M_AXI_BRESP);
            r_rdata     <= '0;
            r_rsp_write <= r_cmd.write;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RD_REQ: begin
          r_cnt <= w_cnt_inc;
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          r_cnt <= w_cnt_inc;
          if (M_AXI_RVALID) begin
            r_resp      <= axi_resp_t'(M_AXI_RRESP);
            r_rdata     <= M_AXI_RDATA;
            r_rsp_write <= r_cmd.write;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;
  assign rsp_cycles    = r_cnt;
  assign M_AXI_AWADDR  = r_cmd.addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_cmd.wdata;
  assign M_AXI_WSTRB   = r_cmd.wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_cmd.addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_host_master.sv
// Directed bench for axi_host_master: the slave side is driven step by step
// with hand-computed expectations for each cycle of interest.
module tb_axi_host_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_cycles;
  logic [31:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  axi_host_master #(.ADDR_W(32), .DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = 8'hFF;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    step(); step();
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rst_cycles", rsp_cycles, 0);
    chk("rst_addr", awaddr, 0);

    // Zero-wait write
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(1'b1, 32'h40, 64'h0000_0000_1234_5678);
    chk("w0_valids", {awvalid, wvalid, cmd_ready}, 3'b110);
    chk("w0_awaddr", awaddr, 32'h40);
    chk("w0_wdata", wdata, 64'h0000_0000_1234_5678);
    step();
    chk("w0_after_hs", {awvalid, wvalid, bready}, 3'b001);
    step();
    chk("w0_rsp_valid", rsp_valid, 1);
    chk("w0_rsp", {rsp_write, rsp_resp}, 3'b100);
    chk("w0_rdata", rsp_rdata, 0);
    chk("w0_cycles", rsp_cycles, 3);
    chk("w0_bready_low", bready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w0_done", {rsp_valid, cmd_ready}, 2'b01);

    // Write with AWREADY delayed 4 cycles
    awready = 1'b0; wready = 1'b1;
    issue(1'b1, 32'h48, 64'hAAAA_5555_0000_FFFF);
    chk("w1_c1", {awvalid, wvalid}, 2'b11);
    step();
    chk("w1_c2", {awvalid, wvalid}, 2'b10);
    step(); step();
    chk("w1_c4", {awvalid, wvalid, bready}, 3'b100);
    step();
    chk("w1_c5", awvalid, 1);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("w1_wr_resp", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
    step();
    chk("w1_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
    chk("w1_cycles", rsp_cycles, 7);
    rsp_ready = 1'b1;
    step();
    chk("w1_one_rsp_a", rsp_valid, 0);
    step();
    rsp_ready = 1'b0;
    chk("w1_one_rsp_b", {rsp_valid, cmd_ready}, 2'b01);

    // Read with ARREADY delayed 2, RVALID delayed 3 more
    bvalid = 1'b0; wready = 1'b0;
    issue(1'b0, 32'h80, 64'h0);
    chk("r0_arvalid", {arvalid, awvalid}, 2'b10);
    chk("r0_araddr", araddr, 32'h80);
    step(); step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r0_rd_data", {arvalid, rready}, 2'b01);
    step(); step(); step();
    chk("r0_waiting", {rready, rsp_valid}, 2'b10);
    rvalid = 1'b1; rdata = 64'h0123_4567_89AB_CDEF; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    chk("r0_rsp", {rsp_valid, rsp_write, rsp_resp, rready}, 5'b10000);
    chk("r0_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("r0_cycles", rsp_cycles, 8);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r0_done", {rsp_valid, cmd_ready}, 2'b01);

    // SLVERR write held while rsp_ready is low
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    issue(1'b1, 32'h50, 64'h1);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("w2_hold", {rsp_valid, rsp_resp, cmd_ready}, 4'b1100);
      chk("w2_hold_cycles", rsp_cycles, 3);
      step();
    end
    bvalid = 1'b0; bresp = 2'b00;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w2_idle", {rsp_valid, cmd_ready}, 2'b01);

    // Reset mid-write, then late responses in IDLE are ignored
    awready = 1'b0; wready = 1'b0;
    issue(1'b1, 32'h60, 64'h2);
    chk("rst_mid_pre", awvalid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    bvalid = 1'b1; rvalid = 1'b1;
    step(); step();
    chk("idle_ignore", {bready, rready, rsp_valid, cmd_ready}, 4'b0001);
    bvalid = 1'b0; rvalid = 1'b0;

    // ARREADY never arrives: counter saturates
    issue(1'b0, 32'h90, 64'h0);
    for (int i = 0; i < 65533; i++) step();
    chk("sat_pre", rsp_cycles, 65534);
    for (int i = 0; i < 70000 - 65533; i++) step();
    chk("sat_cycles", rsp_cycles, 65535);
    chk("sat_state", {arvalid, rready, rsp_valid}, 3'b100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat_reset", {arvalid, cmd_ready, rsp_cycles}, {1'b0, 1'b1, 16'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
